// File: rtl/uart_tx_frame.sv
// UART transmitter: serialises one DATA_BITS word per start/ready handshake,
// LSB first, with optional parity and one or two stop bits.
module uart_tx_frame #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 ready,
  output logic                 done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [IW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 baud_tc;

  assign baud_tc = (baud_q == BAUD_LAST);

  // bit_q is the data bit index in DATA and the stop bit index in STOP.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (start && ready_q) begin
          data_d  = data;
          state_d = START;
        end
      end
      START: begin
        if (baud_tc) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_tc) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      PARITY: begin
        if (baud_tc) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_tc) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up
  // with the state they describe.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_d];
      PARITY:  tx_d = (^data_d) ^ PAR_ODD;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    ready_d = (state_d == IDLE);
    done_d  = (state_d == STOP) && (baud_d == BAUD_LAST) && (bit_d == STOP_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign done  = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: five parameter sets driven one at a time, each
// captured frame compared against a bit-period model of the UART line.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] start_v;
  logic [8:0] data_v;
  logic [4:0] tx_v, ready_v, done_v;

  int n_cmp = 0;
  int n_fail = 0;

  localparam int CFG_DB  [5] = '{8, 8, 8, 7, 9};
  localparam int CFG_CPB [5] = '{4, 4, 4, 4, 5};
  localparam int CFG_PE  [5] = '{0, 1, 1, 0, 1};
  localparam int CFG_PO  [5] = '{0, 0, 1, 0, 1};
  localparam int CFG_SB  [5] = '{1, 1, 1, 2, 2};

  logic [127:0] obs_tx, obs_rdy, obs_done;
  logic [127:0] exp_tx, exp_rdy, exp_done;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .data(data_v[7:0]),
    .tx(tx_v[0]), .ready(ready_v[0]), .done(done_v[0]));
  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .data(data_v[7:0]),
    .tx(tx_v[1]), .ready(ready_v[1]), .done(done_v[1]));
  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .data(data_v[7:0]),
    .tx(tx_v[2]), .ready(ready_v[2]), .done(done_v[2]));
  uart_tx_frame #(.DATA_BITS(7), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .data(data_v[6:0]),
    .tx(tx_v[3]), .ready(ready_v[3]), .done(done_v[3]));
  uart_tx_frame #(.DATA_BITS(9), .CLKS_PER_BIT(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u4 (
    .clk(clk), .rst(rst), .start(start_v[4]), .data(data_v[8:0]),
    .tx(tx_v[4]), .ready(ready_v[4]), .done(done_v[4]));

  function automatic int flen(input int c);
    return (1 + CFG_DB[c] + CFG_PE[c] + CFG_SB[c]) * CFG_CPB[c];
  endfunction

  // Line level at cycle t (1-based) of a frame carrying word w.
  function automatic logic model_tx(input int c, input logic [8:0] w, input int t);
    int pos;
    int ones;
    pos  = (t - 1) / CFG_CPB[c];
    ones = 0;
    if (pos == 0) return 1'b0;
    if (pos <= CFG_DB[c]) return w[pos-1];
    if (CFG_PE[c] != 0 && pos == CFG_DB[c] + 1) begin
      for (int i = 0; i < CFG_DB[c]; i++) ones += int'(w[i]);
      return ((ones % 2) ^ CFG_PO[c]) != 0;
    end
    return 1'b1;
  endfunction

  task automatic build_expected(input int c, input logic [8:0] w1, input logic [8:0] w2,
                                input int frames, input int extra, output int n);
    int f;
    f = flen(c);
    exp_tx = '0; exp_rdy = '0; exp_done = '0;
    n = 0;
    for (int fr = 0; fr < frames; fr++) begin
      for (int t = 1; t <= f; t++) exp_tx[n+t] = model_tx(c, (fr == 0) ? w1 : w2, t);
      exp_done[n+f] = 1'b1;
      n = n + f + 1;
      exp_tx[n]  = 1'b1;
      exp_rdy[n] = 1'b1;
    end
    for (int e = 0; e < extra; e++) begin
      n++;
      exp_tx[n]  = 1'b1;
      exp_rdy[n] = 1'b1;
    end
  endtask

  task automatic wait_ready(input int c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready_v[c] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL ready_timeout cfg%0d: ready=%b after 200 cycles, required 1", c, ready_v[c]);
    end
  endtask

  // Accepts word w on DUT c and records n cycles after the accepting edge.
  task automatic run_frame(input int c, input logic [8:0] w, input int n,
                           input logic [127:0] start_sched, input int sw_t, input logic [8:0] sw_data);
    bit ok;
    obs_tx = '0; obs_rdy = '0; obs_done = '0;
    wait_ready(c, ok);
    if (!ok) return;
    start_v[c] = 1'b1;
    data_v     = w;
    for (int t = 1; t <= n; t++) begin
      @(negedge clk);
      obs_tx[t]   = tx_v[c];
      obs_rdy[t]  = ready_v[c];
      obs_done[t] = done_v[c];
      if (t == sw_t) data_v = sw_data;
      start_v[c] = start_sched[t];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_v = 5'b00001; data_v = 9'h0FF;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (tx_v !== 5'h1F) begin n_fail++; $display("[TB] FAIL reset_tx: got %b want 11111", tx_v); end
    n_cmp++;
    if (ready_v !== 5'h00) begin n_fail++; $display("[TB] FAIL reset_ready: got %b want 00000", ready_v); end
    n_cmp++;
    if (done_v !== 5'h00) begin n_fail++; $display("[TB] FAIL reset_done: got %b want 00000", done_v); end
    start_v = '0;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ready_v !== 5'h1F) begin n_fail++; $display("[TB] FAIL post_reset_ready: got %b want 11111", ready_v); end
    n_cmp++;
    if (tx_v !== 5'h1F) begin n_fail++; $display("[TB] FAIL post_reset_tx: got %b want 11111", tx_v); end
  endtask

  task automatic test_basic();
    logic [8:0] w;
    int n;
    for (int k = 0; k < 5; k++) begin
      w = (k == 0) ? 9'h0A5 : 9'($urandom_range(0, 255));
      build_expected(0, w, w, 1, 0, n);
      run_frame(0, w, n, '0, 1, 9'($urandom_range(0, 511)));
      n_cmp++;
      if (obs_tx !== exp_tx) begin n_fail++; $display("[TB] FAIL basic_tx w=%h: got %h want %h", w, obs_tx, exp_tx); end
      n_cmp++;
      if (obs_done !== exp_done) begin n_fail++; $display("[TB] FAIL basic_done w=%h: got %h want %h", w, obs_done, exp_done); end
      n_cmp++;
      if (obs_rdy !== exp_rdy) begin n_fail++; $display("[TB] FAIL basic_ready w=%h: got %h want %h", w, obs_rdy, exp_rdy); end
    end
  endtask

  task automatic test_parity();
    logic [8:0] w;
    logic       want_par;
    int n;
    for (int c = 1; c <= 2; c++) begin
      for (int k = 0; k < 4; k++) begin
        w = (k == 0) ? 9'h0A5 : (k == 1) ? 9'h007 : 9'($urandom_range(0, 255));
        build_expected(c, w, w, 1, 0, n);
        run_frame(c, w, n, '0, 1, 9'($urandom_range(0, 511)));
        n_cmp++;
        if (obs_tx !== exp_tx) begin n_fail++; $display("[TB] FAIL parity_tx cfg%0d w=%h: got %h want %h", c, w, obs_tx, exp_tx); end
        n_cmp++;
        if (obs_done !== exp_done) begin n_fail++; $display("[TB] FAIL parity_done cfg%0d w=%h: got %h want %h", c, w, obs_done, exp_done); end
        if (k < 2) begin
          want_par = (k == 0) ? (c == 2) : (c == 1);
          n_cmp++;
          if (obs_tx[37] !== want_par) begin
            n_fail++;
            $display("[TB] FAIL parity_bit cfg%0d w=%h: got %b want %b", c, w, obs_tx[37], want_par);
          end
        end
      end
    end
  endtask

  task automatic test_two_stop();
    logic [8:0] w;
    int n;
    for (int k = 0; k < 6; k++) begin
      int c;
      c = (k < 3) ? 3 : 4;
      w = (k == 0) ? 9'h041 : 9'($urandom_range(0, 511));
      build_expected(c, w, w, 1, 2, n);
      run_frame(c, w, n, '0, 1, 9'($urandom_range(0, 511)));
      n_cmp++;
      if (obs_tx !== exp_tx) begin n_fail++; $display("[TB] FAIL stop2_tx cfg%0d w=%h: got %h want %h", c, w, obs_tx, exp_tx); end
      n_cmp++;
      if (obs_done !== exp_done) begin n_fail++; $display("[TB] FAIL stop2_done cfg%0d w=%h: got %h want %h", c, w, obs_done, exp_done); end
      if (k == 0) begin
        n_cmp++;
        if (obs_done[40] !== 1'b1 || $countones(obs_done) != 1) begin
          n_fail++;
          $display("[TB] FAIL stop2_len: done vector %h, required single pulse at cycle 40", obs_done);
        end
      end
    end
  endtask

  task automatic test_busy();
    logic [127:0] sched;
    int n;
    sched = '0;
    for (int t = 10; t <= 30; t++) sched[t] = 1'b1;
    build_expected(0, 9'h03C, 9'h03C, 1, 8, n);
    run_frame(0, 9'h03C, n, sched, 10, 9'h0FF);
    n_cmp++;
    if (obs_tx !== exp_tx) begin n_fail++; $display("[TB] FAIL busy_tx: got %h want %h", obs_tx, exp_tx); end
    n_cmp++;
    if (obs_rdy !== exp_rdy) begin n_fail++; $display("[TB] FAIL busy_ready: got %h want %h", obs_rdy, exp_rdy); end
    n_cmp++;
    if (obs_done !== exp_done) begin n_fail++; $display("[TB] FAIL busy_done: got %h want %h", obs_done, exp_done); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] sched;
    logic [8:0]   w1, w2;
    int n;
    for (int k = 0; k < 2; k++) begin
      int c;
      c  = (k == 0) ? 0 : 4;
      w1 = (k == 0) ? 9'h055 : 9'($urandom_range(0, 511));
      w2 = (k == 0) ? 9'h0AA : 9'($urandom_range(0, 511));
      sched = '0;
      for (int t = 1; t <= flen(c) + 1; t++) sched[t] = 1'b1;
      build_expected(c, w1, w2, 2, 0, n);
      run_frame(c, w1, n, sched, 1, w2);
      n_cmp++;
      if (obs_tx !== exp_tx) begin n_fail++; $display("[TB] FAIL b2b_tx cfg%0d: got %h want %h", c, obs_tx, exp_tx); end
      n_cmp++;
      if (obs_done !== exp_done) begin n_fail++; $display("[TB] FAIL b2b_done cfg%0d: got %h want %h", c, obs_done, exp_done); end
      n_cmp++;
      if (obs_rdy !== exp_rdy) begin n_fail++; $display("[TB] FAIL b2b_ready cfg%0d: got %h want %h", c, obs_rdy, exp_rdy); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    run_frame(0, 9'h0F0, 18, '0, 0, 9'h000);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (tx_v[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_tx: got %b want 1", tx_v[0]); end
    n_cmp++;
    if (ready_v[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_ready: got %b want 0", ready_v[0]); end
    n_cmp++;
    if (done_v[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_done: got %b want 0", done_v[0]); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ready_v[0] !== 1'b1 || tx_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midrst_release: tx/ready/done=%b%b%b want 110", tx_v[0], ready_v[0], done_v[0]);
    end
    build_expected(0, 9'h081, 9'h081, 1, 0, n);
    run_frame(0, 9'h081, n, '0, 0, 9'h000);
    n_cmp++;
    if (obs_tx !== exp_tx) begin n_fail++; $display("[TB] FAIL midrst_frame_tx: got %h want %h", obs_tx, exp_tx); end
    n_cmp++;
    if (obs_done !== exp_done) begin n_fail++; $display("[TB] FAIL midrst_frame_done: got %h want %h", obs_done, exp_done); end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_two_stop();
    test_busy();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter that serialises one parallel word per start/ready handshake.
- Built-in baud divider holds each bit for CLKS_PER_BIT clocks.
- Configurable data width, optional even/odd parity and 1 or 2 stop bits.
- Sits between a host-side byte source (FIFO or control FSM) and the serial TX pin; pairs with the UART receiver on the same link.

Parameters:
DATA_BITS, 8, payload bits per frame; legal 5..9
CLKS_PER_BIT, 16, clk cycles per serial bit; legal >= 2
PARITY_EN, 0, 1 = append parity bit after data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
STOP_BITS, 1, stop bits per frame; legal 1 or 2

Ports:
clk  input  1  single clock; all logic on posedge
rst  input  1  synchronous active-high reset
start  input  1  request to send; accepted only in a cycle where ready=1
data  input  DATA_BITS  word to send; sampled in the accepting cycle
tx  output  1  serial line, idle high
ready  output  1  high when idle and able to accept start
done  output  1  one-cycle pulse on the last clk of the final stop bit

Behaviour:
- Reset: one clock, synchronous, active-high (already decided). While rst=1: tx=1, ready=0, done=0, FSM=IDLE, all counters 0. First cycle after rst falls: ready=1.
- Handshake: start && ready at edge N latches data into an internal register and moves FSM to START. From N+1: tx=0, ready=0. Changes on data after N have no effect on the frame.
- start while ready=0 is ignored; it is not queued.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accepted start.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> PARITY if PARITY_EN, else -> STOP, after DATA_BITS bit periods.
  - PARITY -> STOP after one bit period.
  - STOP -> IDLE after STOP_BITS bit periods.
- Baud counter: counts 0..CLKS_PER_BIT-1 within each bit; it wraps to 0 and advances bit index/state at terminal count. Width is clog2(CLKS_PER_BIT).
- Bit index: counts 0..DATA_BITS-1. Data is sent LSB first, so bit k is driven during DATA bit period k.
- tx per state:
  - START: 0.
  - DATA: latched[k].
  - PARITY: XOR of latched bits, XOR PARITY_ODD.
  - STOP: 1.
  - IDLE: 1.
- tx is driven from a register (glitch-free).
- Frame length: (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles, from first tx=0 cycle to end of last stop cycle.
- done=1 for exactly one cycle: the last cycle of the final stop bit. The next cycle is IDLE with ready=1.
- Back-to-back: if start is held high, the next frame is accepted in the first ready cycle. This gives exactly one idle cycle (tx=1) between frames, which is legal UART.
- Reset mid-frame: the frame aborts. The cycle after the rst edge has tx=1, ready=0 and done=0, with no partial stop or done.
- No illegal-state lockup: an unreachable state encoding returns to IDLE with tx=1.

Test Plan:
- Basic frame (DATA_BITS=8, CLKS_PER_BIT=4, no parity, 1 stop): send data=0xA5 -> tx=0 for 4 clks, then bits 1,0,1,0,0,1,0,1 each 4 clks, then 1 for 4 clks. done pulses at cycle 40 after accept. ready=1 at cycle 41.
- Parity: PARITY_EN=1 with 0xA5 -> parity bit 0 (even) / 1 (PARITY_ODD=1). With 0x07 -> 1 (even) / 0 (odd). Frame is 44 cycles at CLKS_PER_BIT=4.
- Two stop bits with DATA_BITS=7: send 0x41 -> stop high for 8 clks, frame is 40 cycles, done once.
- Start while busy: assert start with data=0xFF mid-frame of 0x3C -> 0x3C frame transmitted unchanged, no second frame, ready stays 0 until end.
- Back-to-back: hold start=1 with 0x55 then 0xAA -> two complete frames separated by exactly one tx=1 idle cycle, and two done pulses.
- Reset mid-frame: assert rst during DATA bit 3 -> next cycle tx=1, ready=0, done=0. After release, ready=1 and a fresh 0x81 frame is transmitted correctly.
